// File: rtl/rx_frame_validator.sv
// rx_frame_validator: latches received frames, checks sync and XOR checksum one byte per cycle,
// and hands good frames to the consumer over a valid/ack handshake.
module rx_frame_validator #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         CNT_W     = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [161:0]     rx_data_in,
  input  logic             rx_ready_in,
  output logic [3:0]       msg_type_out,
  output logic [141:0]     payload_out,
  output logic             valid_out,
  input  logic             ack_in,
  output logic             busy_out,
  output logic [CNT_W-1:0] bad_cnt_out,
  output logic [CNT_W-1:0] drop_cnt_out
);
  typedef enum logic [1:0] {IDLE, CHECK, HOLD} state_t;
  state_t       state;
  logic [161:0] frame;
  logic [7:0]   acc;
  logic [4:0]   idx;
  logic [7:0]   base;
  logic [7:0]   chunk;
  logic [7:0]   acc_nxt;
  logic         last;
  logic         pass;
  // Chunk 19 only carries the two payload bits left above the checksum byte.
  always_comb begin
    base    = 8'd161 - {idx, 3'b000};
    last    = idx == 5'd19;
    chunk   = last ? {6'b0, frame[9:8]} : frame[base -: 8];
    acc_nxt = acc ^ chunk;
    pass    = (frame[161:154] == SYNC_BYTE) && (acc_nxt == frame[7:0]);
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= IDLE;
      frame        <= '0;
      acc          <= '0;
      idx          <= '0;
      msg_type_out <= '0;
      payload_out  <= '0;
      valid_out    <= 1'b0;
      busy_out     <= 1'b0;
      bad_cnt_out  <= '0;
      drop_cnt_out <= '0;
    end else begin
      case (state)
        IDLE: if (rx_ready_in) begin
          frame    <= rx_data_in;
          acc      <= '0;
          idx      <= '0;
          busy_out <= 1'b1;
          state    <= CHECK;
        end
        CHECK: begin
          acc <= acc_nxt;
          idx <= idx + 5'd1;
          if (rx_ready_in && ~&drop_cnt_out) drop_cnt_out <= drop_cnt_out + CNT_W'(1);
          if (last) begin
            busy_out <= 1'b0;
            if (pass) begin
              msg_type_out <= frame[153:150];
              payload_out  <= frame[149:8];
              valid_out    <= 1'b1;
              state        <= HOLD;
            end else begin
              if (~&bad_cnt_out) bad_cnt_out <= bad_cnt_out + CNT_W'(1);
              state <= IDLE;
            end
          end
        end
        HOLD: if (ack_in) begin
          valid_out <= 1'b0;
          state     <= rx_ready_in ? CHECK : IDLE;
          if (rx_ready_in) begin
            frame    <= rx_data_in;
            acc      <= '0;
            idx      <= '0;
            busy_out <= 1'b1;
          end
        end else if (rx_ready_in && ~&drop_cnt_out) begin
          drop_cnt_out <= drop_cnt_out + CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rx_frame_validator.sv
// tb_rx_frame_validator: directed frames; a monitor pops expected type/payload on each valid_out rise.
module tb_rx_frame_validator;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [161:0] rx_data = '0;
  logic         rx_ready = 1'b0;
  logic         ack = 1'b0;
  logic [3:0]   msg_type;
  logic [141:0] payload;
  logic         valid;
  logic         busy;
  logic [7:0]   bad_cnt;
  logic [7:0]   drop_cnt;
  int           vectors = 0;
  int           miscompares = 0;
  int           delivered = 0;
  logic         prev_valid = 1'b0;
  logic [145:0] exp_q[$];

  rx_frame_validator dut (
    .clk_in(clk), .rst_in(rst), .rx_data_in(rx_data), .rx_ready_in(rx_ready),
    .msg_type_out(msg_type), .payload_out(payload), .valid_out(valid), .ack_in(ack),
    .busy_out(busy), .bad_cnt_out(bad_cnt), .drop_cnt_out(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bit-wise view of the checksum: frame bit i>=10 lands on bit (i-10)%8, bits 9:8 on bits 1:0.
  function automatic logic [7:0] model_cs(input logic [161:0] f);
    logic [7:0] c = '0;
    for (int i = 10; i < 162; i++) c[(i - 10) % 8] ^= f[i];
    c[0] ^= f[8];
    c[1] ^= f[9];
    return c;
  endfunction

  function automatic logic [161:0] mk(input logic [7:0] s, input logic [3:0] t, input logic [141:0] p);
    logic [161:0] f = {s, t, p, 8'h00};
    f[7:0] = model_cs(f);
    return f;
  endfunction

  task automatic send(input logic [161:0] f);
    @(negedge clk);
    rx_data  = f;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!valid && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  always @(negedge clk) begin
    prev_valid <= valid;
    if (valid && !prev_valid) begin
      delivered++;
      if (exp_q.size() == 0) check("unexpected_frame", {msg_type, payload}, '0);
      else check("frame_out", {msg_type, payload}, exp_q.pop_front());
    end
  end

  initial begin
    int n, b, v;
    logic [161:0] fa, fb, fc, fe;
    repeat (3) @(negedge clk);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_type", msg_type, 0);
    check("rst_payload", payload, 0);
    check("rst_bad", bad_cnt, 0);
    check("rst_drop", drop_cnt, 0);
    rst = 1'b0;
    // good frame, checksum A5^30 = 95
    exp_q.push_back({4'h3, 142'h0});
    send({8'hA5, 4'h3, 142'h0, 8'h95});
    check("good_busy", busy, 1);
    wait_valid(n);
    check("good_latency", n, 20);
    check("good_bad", bad_cnt, 0);
    ack_pulse();
    check("ack_valid", valid, 0);
    check("ack_type_kept", msg_type, 4'h3);
    // bad checksum
    send({8'hA5, 4'h3, 142'h0, 8'h94});
    b = busy; v = valid;
    repeat (29) begin
      @(negedge clk);
      b += busy;
      v |= valid;
    end
    check("badcs_busy_cycles", b, 20);
    check("badcs_no_valid", v, 0);
    check("badcs_cnt", bad_cnt, 1);
    // bad sync
    send({8'hA4, 4'h3, 142'h0, 8'h94});
    repeat (25) @(negedge clk);
    check("badsync_cnt", bad_cnt, 2);
    check("badsync_no_valid", valid, 0);
    // overflow during CHECK then during HOLD
    fa = mk(8'hA5, 4'h5, 142'hDEADBEEF01234567);
    exp_q.push_back({4'h5, 142'hDEADBEEF01234567});
    send(fa);
    repeat (4) @(negedge clk);
    send(mk(8'hA5, 4'h9, 142'h5));
    check("drop_check", drop_cnt, 1);
    wait_valid(n);
    check("ovf_valid", valid, 1);
    send(mk(8'hA5, 4'h7, 142'h7));
    check("drop_hold", drop_cnt, 2);
    check("hold_valid", valid, 1);
    check("hold_type", msg_type, 4'h5);
    ack_pulse();
    // back-to-back: ack and new frame on the same edge
    fb = mk(8'hA5, 4'hC, 142'h0F0F);
    exp_q.push_back({4'hC, 142'h0F0F});
    send(fb);
    wait_valid(n);
    check("b2b_first_latency", n, 20);
    fc = mk(8'hA5, 4'hA, 142'h123456789ABC);
    exp_q.push_back({4'hA, 142'h123456789ABC});
    @(negedge clk);
    ack = 1'b1; rx_data = fc; rx_ready = 1'b1;
    @(negedge clk);
    ack = 1'b0; rx_ready = 1'b0;
    check("b2b_valid", valid, 0);
    check("b2b_busy", busy, 1);
    check("b2b_drop", drop_cnt, 2);
    wait_valid(n);
    check("b2b_latency", n, 20);
    ack_pulse();
    // saturation of the bad counter
    repeat (253) begin
      send({8'hA4, 4'h3, 142'h0, 8'h94});
      repeat (20) @(negedge clk);
    end
    check("sat_reach", bad_cnt, 255);
    repeat (47) begin
      send({8'hA4, 4'h3, 142'h0, 8'h94});
      repeat (20) @(negedge clk);
    end
    check("sat_hold", bad_cnt, 255);
    check("sat_drop", drop_cnt, 2);
    // reset in the middle of CHECK
    send(mk(8'hA5, 4'h6, 142'h55));
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_valid", valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_type", msg_type, 0);
    check("mid_rst_payload", payload, 0);
    check("mid_rst_bad", bad_cnt, 0);
    check("mid_rst_drop", drop_cnt, 0);
    fe = mk(8'hA5, 4'h2, 142'hABC);
    exp_q.push_back({4'h2, 142'hABC});
    send(fe);
    wait_valid(n);
    check("post_rst_latency", n, 20);
    ack_pulse();
    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    check("delivered", delivered, 5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rx_frame_validator.md
Name: rx_frame_validator

Overview:
- Sits directly downstream of the serial receiver and consumes its 162-bit parallel word plus one-cycle ready strobe.
- Latches each received frame and checks the sync byte and an XOR checksum sequentially, one byte per cycle.
- Presents good frames as message type plus payload on a valid/ack handshake to game logic.
- Counts bad frames and dropped frames.

Parameters:
- SYNC_BYTE, 8'hA5, required value of frame bits [161:154].
- CNT_W, 8, width of the saturating error and overflow counters.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous active-high reset.
- rx_data_in  input  162  received frame from the serial receiver.
- rx_ready_in  input  1  one-cycle strobe; rx_data_in is valid in this cycle.
- msg_type_out  output  4  frame bits [153:150] of the accepted frame.
- payload_out  output  142  frame bits [149:8] of the accepted frame.
- valid_out  output  1  msg_type_out and payload_out hold a checked frame.
- ack_in  input  1  consumer accepts the frame; sampled only while valid_out=1.
- busy_out  output  1  high in the CHECK state.
- bad_cnt_out  output  CNT_W  frames failing the sync or checksum test, saturating.
- drop_cnt_out  output  CNT_W  frames discarded because the block was not free, saturating.

Behaviour:
- Frame layout: [161:154] sync, [153:150] type, [149:8] payload, [7:0] checksum.
- Checksum chunks: chunk k = rx[161-8k -: 8] for k=0..18, and chunk 19 = {6'b0, rx[9:8]}.
- Required checksum = XOR of chunks 0..19.
- Reset (rst_in high, sampled on clk_in edge):
  - state returns to IDLE;
  - valid_out=0, busy_out=0;
  - msg_type_out=0, payload_out=0;
  - both counters 0;
  - internal frame register, accumulator and chunk index are cleared.
- Reset mid-CHECK or mid-HOLD abandons the frame and produces no counter update.
- State IDLE:
  - if rx_ready_in=1, latch rx_data_in, set accumulator=0 and index=0, go to CHECK;
  - otherwise stay in IDLE.
- State CHECK (busy_out=1):
  - each cycle, accumulator ^= chunk[index] and index++;
  - exactly 20 cycles are spent in CHECK;
  - on the cycle processing chunk 19, evaluate pass = (latched[161:154]==SYNC_BYTE) && (final accumulator == latched[7:0]).
  - On pass: go to HOLD, load msg_type_out and payload_out, set valid_out=1.
  - On fail: increment bad_cnt_out (saturate at all-ones) and return to IDLE; outputs keep their previous values.
- Latency: rx_ready_in sampled at edge E0 means valid_out rises at edge E0+20 and is visible in the cycle after that edge.
- State HOLD:
  - valid_out, msg_type_out and payload_out stay stable until ack_in=1 is sampled;
  - on that edge valid_out drops to 0 and the state goes to IDLE;
  - data outputs keep their last value after valid_out falls.
- Frames arriving when the block is not free:
  - rx_ready_in in CHECK: frame discarded, drop_cnt_out++ (saturating).
  - rx_ready_in in HOLD with ack_in=0: frame discarded, drop_cnt_out++.
  - rx_ready_in in HOLD with ack_in=1 on the same edge: the ack completes, the new frame is latched, and the state goes directly to CHECK (valid_out=0, no drop).
- ack_in while not in HOLD is ignored.
- Counters saturate at 2^CNT_W-1 and never wrap.
- A frame that fails while bad_cnt_out is saturated leaves the counter unchanged.

Test Plan:
- Good frame: sync A5, type 4'h3, payload 0, checksum 8'h95 (A5^30), one rx_ready_in pulse -> valid_out rises 20 edges later, msg_type_out=3, payload_out=0, bad_cnt_out=0; ack_in pulse -> valid_out=0 on the next edge.
- Bad checksum: same frame with checksum 8'h94 -> valid_out stays 0, bad_cnt_out=1, busy_out high for exactly 20 cycles. Bad sync: sync 8'hA4, checksum 8'h94 -> bad_cnt_out=2.
- Overflow: second rx_ready_in pulse 5 cycles after the first -> drop_cnt_out=1, first frame still delivered; third pulse during HOLD with ack_in=0 -> drop_cnt_out=2.
- Back-to-back: rx_ready_in and ack_in on the same edge in HOLD -> no drop; second frame delivered 20 edges later with its own type and payload.
- Saturation and reset: 300 bad frames -> bad_cnt_out=255. Reset asserted in mid-CHECK -> all outputs 0, and the next good frame is delivered normally.
